// File: rtl/pwm_audio_out.sv
// pwm_audio_out -- final audio output stage.
//
// Captures the 8-bit mixed sample once per sample period and turns it into a
// single-bit PWM stream (256 clk per PWM period) for the board's RC low-pass
// filter. A linear gain ramp is applied when playback starts and stops, so the
// output glides to and from mid-scale (silence) without a click.
//
// Optional build macro: PWM_CLIP_DETECT_EN adds a sticky clip flag that is set
// when a full-scale sample (8'h00 or 8'hFF) is captured.
//
// Parameters:
//   PERIODS_PER_SAMPLE  PWM periods per audio sample (1..16)
//   RAMP_STEP           gain change per sample period while ramping (1..256)
//
// Ports:
//   clk         system clock
//   n_rst       asynchronous active-low reset
//   en          1 = play, 0 = ramp down, then stop
//   sample_in   unsigned offset-binary sample (8'h80 = silence)
//   sample_req  one-cycle pulse; sample_in is captured on this cycle's edge
//   pwm_out     registered PWM bit
//   active      1 whenever the block is not idle
//   clip        sticky clip flag              (PWM_CLIP_DETECT_EN only)
//   clr_clip    clears clip, set wins a tie   (PWM_CLIP_DETECT_EN only)
module pwm_audio_out #(
    parameter int PERIODS_PER_SAMPLE = 4,
    parameter int RAMP_STEP          = 1
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       en,
    input  logic [7:0] sample_in,
    output logic       sample_req,
    output logic       pwm_out,
    output logic       active
`ifdef PWM_CLIP_DETECT_EN
    ,
    output logic       clip,
    input  logic       clr_clip
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        PLAY,
        RAMP_DOWN
    } state_t;

    localparam int              PER_W    = 4;
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIODS_PER_SAMPLE - 1);
    localparam logic [8:0]      GAIN_MAX = 9'd256;
    localparam logic [8:0]      STEP     = 9'(RAMP_STEP);

    state_t           state;
    logic [7:0]       pwm_cnt;
    logic [PER_W-1:0] per_cnt;
    logic [7:0]       sample_reg;
    logic [7:0]       duty_reg;
    logic [8:0]       gain;

    logic             pb;
    logic             sb;
    logic [9:0]       gain_sum;
    logic [8:0]       gain_up;
    logic [8:0]       gain_down;
    logic signed [8:0]  s;
    logic signed [17:0] s_ext;
    logic signed [17:0] g_ext;
    logic signed [17:0] prod;
    logic [7:0]       duty;
    logic             unused_prod_bits;

    // Period and sample boundaries. pwm_cnt sits at 0 in IDLE, so neither
    // boundary can fire there.
    assign pb         = (state != IDLE) && (pwm_cnt == 8'hFF);
    assign sb         = pb && (per_cnt == PER_LAST);
    assign sample_req = sb;

    // Saturating ramp arithmetic; the 10-bit sum cannot wrap for any legal step.
    assign gain_sum  = {1'b0, gain} + {1'b0, STEP};
    assign gain_up   = (gain_sum > 10'd256) ? GAIN_MAX : gain_sum[8:0];
    assign gain_down = (gain > STEP) ? (gain - STEP) : 9'd0;

    // Scale the sample around mid-scale: duty = 128 + ((sample-128)*gain >>> 8).
    // |s*gain| <= 32768, so bits [15:8] hold the whole shifted result and the
    // 8-bit sum never leaves 0..255.
    assign s     = $signed({1'b0, sample_reg}) - 9'sd128;
    assign s_ext = {{9{s[8]}}, s};
    assign g_ext = {9'd0, gain};
    assign prod  = s_ext * g_ext;
    assign duty  = 8'd128 + prod[15:8];

    // Product bits outside the duty window carry no information.
    assign unused_prod_bits = ^{prod[17:16], prod[7:0]};

    // NOTE: every register below is assigned with <= so all of them update
    // from the same pre-edge values, which the duty and gain timing relies on.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            active     <= 1'b0;
            pwm_cnt    <= 8'd0;
            per_cnt    <= '0;
            sample_reg <= 8'h80;
            gain       <= 9'd0;
            duty_reg   <= 8'h80;
            pwm_out    <= 1'b0;
        end else begin
            // Compares against the registered duty, so a new duty value only
            // takes effect from the start of a PWM period.
            pwm_out <= (state != IDLE) && (pwm_cnt < duty_reg);

            if (state != IDLE) begin
                pwm_cnt <= pwm_cnt + 8'd1;
            end

            if (pb) begin
                duty_reg <= duty;
                per_cnt  <= (per_cnt == PER_LAST) ? '0 : per_cnt + PER_W'(1);
            end

            if (sb) begin
                sample_reg <= sample_in;
            end

            case (state)
                IDLE: begin
                    if (en) begin
                        state  <= RAMP_UP;
                        active <= 1'b1;
                    end
                end
                RAMP_UP: begin
                    if (sb) begin
                        gain <= gain_up;
                    end
                    if (!en) begin
                        state <= RAMP_DOWN;
                    end else if (sb && gain_up == GAIN_MAX) begin
                        state <= PLAY;
                    end
                end
                PLAY: begin
                    if (!en) begin
                        state <= RAMP_DOWN;
                    end
                end
                RAMP_DOWN: begin
                    if (sb) begin
                        gain <= gain_down;
                    end
                    if (sb && gain_down == 9'd0) begin
                        state   <= IDLE;
                        active  <= 1'b0;
                        pwm_cnt <= 8'd0;
                        per_cnt <= '0;
                    end else if (en) begin
                        state <= RAMP_UP;
                    end
                end
                default: begin
                    state  <= IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end

`ifdef PWM_CLIP_DETECT_EN
    // Sticky full-scale detector on the captured sample; a capture that clips
    // outranks a simultaneous clear so no clip event is ever lost.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            clip <= 1'b0;
        end else if (sb && (sample_in == 8'h00 || sample_in == 8'hFF)) begin
            clip <= 1'b1;
        end else if (clr_clip) begin
            clip <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_pwm_audio_out.sv
// tb_pwm_audio_out -- self-checking bench for pwm_audio_out.
//
// The reference model works one PWM period at a time: for each period it
// predicts the number of high clocks (the duty in force), whether and where the
// sample request pulses, and the activity / clip flags at the period's end.
// Gain, captured sample and play state are tracked with plain integers.
module tb_pwm_audio_out;

    localparam int PPS  = 4;
    localparam int STEP = 64;

    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_PLAY = 2;
    localparam int M_DOWN = 3;

    logic       clk       = 1'b0;
    logic       n_rst     = 1'b1;
    logic       en        = 1'b0;
    logic       clr_clip  = 1'b0;
    logic [7:0] sample_in = 8'h80;
    logic       sample_req;
    logic       pwm_out;
    logic       active;
`ifdef PWM_CLIP_DETECT_EN
    logic       clip;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int p_idx    = 0;

    // Reference model state.
    int st_m;
    int gain_m;
    int smp_m;
    int duty_m;
    int per_m;
    bit clip_m;

    always #5 clk = ~clk;

    pwm_audio_out #(
        .PERIODS_PER_SAMPLE(PPS),
        .RAMP_STEP         (STEP)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .en        (en),
        .sample_in (sample_in),
        .sample_req(sample_req),
        .pwm_out   (pwm_out),
        .active    (active)
`ifdef PWM_CLIP_DETECT_EN
        ,
        .clip      (clip),
        .clr_clip  (clr_clip)
`endif
    );

    // Duty a sample produces at a given gain: mid-scale plus the offset scaled
    // by gain/256, rounded toward minus infinity.
    function automatic int duty_of(input int smp, input int g);
        int p;
        int q;
        p = (smp - 128) * g;
        if (p >= 0) q = p / 256;
        else        q = -((-p + 255) / 256);
        return (128 + q) & 255;
    endfunction

    function automatic logic [7:0] pick_sample();
        case ($urandom_range(0, 5))
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return 8'h80;
            3:       return 8'h40;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic model_reset();
        st_m   = M_IDLE;
        gain_m = 0;
        smp_m  = 128;
        duty_m = 128;
        per_m  = 0;
        clip_m = 1'b0;
    endtask

    // Called on a falling edge while idle; playback starts on the next edge.
    task automatic start_from_idle(input string tag);
        en = 1'b1;
        @(negedge clk);
        n_checks++;
        if (active !== 1'b1) $display("FAIL %s_active: got %0b expected 1", tag, active);
        else n_pass++;
        st_m = M_UP;
    endtask

    // One full PWM period, starting on the falling edge that ends the previous
    // one. clr_at >= 0 pulses clr_clip for one clock at that offset (254 is the
    // period-boundary clock).
    task automatic run_period(input int clr_at);
        int highs;
        int req_n;
        int req_pos;
        int got_pos;
        int exp_pos;
        int next_duty;
        bit sb_m;

        if (st_m != M_IDLE) begin
            if (!en && st_m != M_DOWN) st_m = M_DOWN;
            else if (en && st_m == M_DOWN) st_m = M_UP;
        end
        sb_m    = (per_m == PPS - 1);
        highs   = 0;
        req_n   = 0;
        req_pos = -1;

        for (int j = 0; j < 256; j++) begin
            @(negedge clk);
            highs += int'(pwm_out);
            if (sample_req === 1'b1) begin
                req_n++;
                req_pos = j;
            end
            clr_clip = (clr_at == j);
        end
        clr_clip = 1'b0;

        // Model update at the period boundary, from pre-boundary values.
        next_duty = duty_of(smp_m, gain_m);
        if (clr_at >= 0) clip_m = 1'b0;
        if (sb_m) begin
            if (sample_in == 8'h00 || sample_in == 8'hFF) clip_m = 1'b1;
            smp_m = int'(sample_in);
            if (st_m == M_UP) begin
                gain_m = (gain_m + STEP > 256) ? 256 : gain_m + STEP;
                if (gain_m == 256) st_m = M_PLAY;
            end else if (st_m == M_DOWN) begin
                gain_m = (gain_m < STEP) ? 0 : gain_m - STEP;
                if (gain_m == 0) st_m = M_IDLE;
            end
            per_m = 0;
        end else begin
            per_m++;
        end

        n_checks++;
        if (highs != duty_m)
            $display("FAIL period%0d_high_clk: got %0d expected %0d", p_idx, highs, duty_m);
        else n_pass++;

        exp_pos = sb_m ? 254 : -1;
        got_pos = (req_n > 1) ? -2 : req_pos;
        n_checks++;
        if (got_pos != exp_pos)
            $display("FAIL period%0d_sample_req_pos: got %0d expected %0d", p_idx, got_pos, exp_pos);
        else n_pass++;

        n_checks++;
        if (active !== (st_m != M_IDLE))
            $display("FAIL period%0d_active: got %0b expected %0b", p_idx, active, st_m != M_IDLE);
        else n_pass++;

`ifdef PWM_CLIP_DETECT_EN
        n_checks++;
        if (clip !== clip_m)
            $display("FAIL period%0d_clip: got %0b expected %0b", p_idx, clip, clip_m);
        else n_pass++;
`endif

        duty_m = next_duty;
        p_idx++;
    endtask

    // Idle watch: no PWM activity, no requests, not active.
    task automatic idle_watch(input string tag, input int cycles);
        int highs;
        int acts;
        int reqs;
        highs = 0;
        acts  = 0;
        reqs  = 0;
        repeat (cycles) begin
            @(negedge clk);
            highs += int'(pwm_out);
            acts  += int'(active);
            reqs  += int'(sample_req);
        end
        n_checks++;
        if (highs != 0) $display("FAIL %s_pwm_high_clk: got %0d expected 0", tag, highs);
        else n_pass++;
        n_checks++;
        if (acts != 0) $display("FAIL %s_active_clk: got %0d expected 0", tag, acts);
        else n_pass++;
        n_checks++;
        if (reqs != 0) $display("FAIL %s_sample_req_clk: got %0d expected 0", tag, reqs);
        else n_pass++;
    endtask

    task automatic check_reset_outputs(input string tag);
        n_checks++;
        if (pwm_out !== 1'b0) $display("FAIL %s_pwm_out: got %0b expected 0", tag, pwm_out);
        else n_pass++;
        n_checks++;
        if (active !== 1'b0) $display("FAIL %s_active: got %0b expected 0", tag, active);
        else n_pass++;
        n_checks++;
        if (sample_req !== 1'b0) $display("FAIL %s_sample_req: got %0b expected 0", tag, sample_req);
        else n_pass++;
`ifdef PWM_CLIP_DETECT_EN
        n_checks++;
        if (clip !== 1'b0) $display("FAIL %s_clip: got %0b expected 0", tag, clip);
        else n_pass++;
`endif
    endtask

    task automatic test_reset();
        en = 1'b0;
        #2 n_rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_reset_outputs("reset");
        n_rst = 1'b1;
        idle_watch("idle_after_reset", 1000);
    endtask

    task automatic test_ramp_up();
        sample_in = 8'hFF;
        start_from_idle("ramp_up");
        // Four ramp sample periods to full gain, then one sample period of play.
        for (int i = 0; i < 5 * PPS; i++) run_period(-1);
    endtask

    task automatic test_play_random();
        for (int i = 0; i < 6 * PPS; i++) begin
            sample_in = (i == 0) ? 8'h40 : pick_sample();
            run_period(-1);
        end
    endtask

`ifdef PWM_CLIP_DETECT_EN
    task automatic test_clip();
        sample_in = 8'h80;
        while (per_m != PPS - 1) run_period(-1);
        sample_in = 8'hFF;
        run_period(-1);             // full-scale capture sets clip
        sample_in = 8'h80;
        run_period(100);            // one-clock clear mid-period
        while (per_m != PPS - 1) run_period(-1);
        sample_in = 8'h00;
        run_period(254);            // clear coincides with a clipping capture
        sample_in = 8'h80;
        while (per_m != PPS - 1) run_period(-1);
        run_period(254);            // clear at a clean capture takes effect
    endtask
`endif

    task automatic test_reset_mid_play();
        sample_in = 8'hFF;
        repeat (PPS) run_period(-1);
        repeat (37) @(negedge clk);
        n_rst = 1'b0;
        #1;
        check_reset_outputs("reset_mid_play");
        @(negedge clk);
        en = 1'b0;
        n_rst = 1'b1;
        model_reset();
        idle_watch("idle_after_mid_reset", 300);
    endtask

    task automatic test_ramp_down_resume();
        int guard;
        sample_in = pick_sample();
        start_from_idle("resume");
        guard = 0;
        while (st_m != M_PLAY && guard < 8 * PPS) begin
            sample_in = pick_sample();
            run_period(-1);
            guard++;
        end
        if (st_m != M_PLAY) begin
            n_checks++;
            $display("FAIL resume_reach_play: got state %0d expected %0d", st_m, M_PLAY);
        end

        // Two ramp-down steps (256 -> 192 -> 128) with full-negative samples,
        // which makes the gain-128 duty land on 64.
        en = 1'b0;
        sample_in = 8'h00;
        for (int i = 0; i < 2 * PPS; i++) run_period(-1);

        // Resume upward from gain 128 through silence samples, then a tone.
        en = 1'b1;
        sample_in = 8'h80;
        for (int i = 0; i < PPS + 1; i++) run_period(-1);
        guard = 0;
        while (st_m != M_PLAY && guard < 8 * PPS) begin
            sample_in = pick_sample();
            run_period(-1);
            guard++;
        end
        if (st_m != M_PLAY) begin
            n_checks++;
            $display("FAIL resume_replay: got state %0d expected %0d", st_m, M_PLAY);
        end

        // Full ramp down to idle with full-scale-low samples at the end.
        en = 1'b0;
        sample_in = 8'h00;
        guard = 0;
        while (st_m != M_IDLE && guard < 8 * PPS) begin
            run_period(-1);
            guard++;
        end
        if (st_m != M_IDLE) begin
            n_checks++;
            $display("FAIL ramp_down_reach_idle: got state %0d expected %0d", st_m, M_IDLE);
        end
        idle_watch("idle_after_ramp_down", 600);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_ramp_up();
        test_play_random();
`ifdef PWM_CLIP_DETECT_EN
        test_clip();
`endif
        test_reset_mid_play();
        test_ramp_down_resume();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
